clock_set_ctrl: RTL

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/clock_set_ctrl.sv
// Time-setting controller for a 12-hour BCD clock: freezes the core, edits a
// shadow copy of hour/minute with auto-repeat increment, then loads it back.
module clock_set_ctrl #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int TIMEOUT_SEC = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mode_pulse,
  input  logic       inc_btn,
  input  logic [3:0] cur_hour_tens,
  input  logic [3:0] cur_hour_units,
  input  logic [3:0] cur_min_tens,
  input  logic [3:0] cur_min_units,
  input  logic       cur_is_am,
  output logic [3:0] set_hour_tens,
  output logic [3:0] set_hour_units,
  output logic [3:0] set_min_tens,
  output logic [3:0] set_min_units,
  output logic       set_is_am,
  output logic       load,
  output logic       run_en,
  output logic       sel_hour,
  output logic       sel_min,
  output logic       blink
);

  localparam int     HOLD_CYC    = CLK_FREQ / 2;
  localparam int     REPEAT_CYC  = CLK_FREQ / 8;
  localparam int     BLINK_CYC   = CLK_FREQ / 4;
  localparam longint TIMEOUT_CYC = longint'(TIMEOUT_SEC) * longint'(CLK_FREQ);
  localparam int     HOLD_W      = $clog2(HOLD_CYC + 1);
  localparam int     BLINK_W     = $clog2(BLINK_CYC + 1);
  localparam int     TMO_W       = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {RUN, SET_HOUR, SET_MIN, COMMIT} state_t;

  state_t             r_state, w_state_next;
  logic               r_inc_prev, r_inc_evt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_next;
  logic [3:0]         r_hr_t, r_hr_u, r_mn_t, r_mn_u;
  logic               r_am;
  logic               r_load, r_run_en, r_sel_hour, r_sel_min, r_blink;
  logic               w_load_next, w_run_en_next, w_sel_hour_next, w_sel_min_next, w_blink_next;
  logic               w_in_set, w_next_in_set, w_enter_set, w_inc_apply, w_timeout, w_cap_valid;

  assign w_in_set      = (r_state == SET_HOUR) || (r_state == SET_MIN);
  assign w_next_in_set = (w_state_next == SET_HOUR) || (w_state_next == SET_MIN);
  assign w_enter_set   = w_next_in_set && (w_state_next != r_state);
  assign w_inc_apply   = r_inc_evt && !mode_pulse && w_in_set;
  assign w_timeout     = w_in_set && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign w_cap_valid   = ((cur_hour_tens == 4'd0) && (cur_hour_units != 4'd0) && (cur_hour_units <= 4'd9)) ||
                         ((cur_hour_tens == 4'd1) && (cur_hour_units <= 4'd2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:      if (mode_pulse) w_state_next = SET_HOUR;
      SET_HOUR: if (mode_pulse) w_state_next = SET_MIN; else if (w_timeout) w_state_next = RUN;
      SET_MIN:  if (mode_pulse) w_state_next = COMMIT;  else if (w_timeout) w_state_next = RUN;
      COMMIT:   w_state_next = RUN;
      default:  w_state_next = RUN;
    endcase
  end

  // A press only arms while already in a SET state with no mode pulse, so a
  // button held across any state change stays silent until re-pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc_prev <= 1'b0;
      r_inc_evt  <= 1'b0;
      r_hold_cnt <= '0;
    end else begin
      r_inc_prev <= inc_btn;
      r_inc_evt  <= 1'b0;
      if (!w_in_set || !inc_btn || mode_pulse) begin
        r_hold_cnt <= '0;
      end else if (!r_inc_prev) begin
        r_hold_cnt <= HOLD_W'(1);
        r_inc_evt  <= 1'b1;
      end else if (r_hold_cnt != '0) begin
        if (r_hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
          r_inc_evt  <= 1'b1;
          r_hold_cnt <= HOLD_W'(HOLD_CYC - REPEAT_CYC);
        end else begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_tmo_cnt <= '0;
    else if (!w_in_set || mode_pulse || r_inc_evt) r_tmo_cnt <= '0;
    else                                          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hr_t <= 4'd1; r_hr_u <= 4'd2; r_mn_t <= 4'd0; r_mn_u <= 4'd0; r_am <= 1'b1;
    end else if ((r_state == RUN) && mode_pulse) begin
      r_hr_t <= w_cap_valid ? cur_hour_tens  : 4'd1;
      r_hr_u <= w_cap_valid ? cur_hour_units : 4'd2;
      r_mn_t <= cur_min_tens;
      r_mn_u <= cur_min_units;
      r_am   <= cur_is_am;
    end else if (w_inc_apply && (r_state == SET_HOUR)) begin
      if ((r_hr_t == 4'd1) && (r_hr_u == 4'd2)) begin
        r_hr_t <= 4'd0; r_hr_u <= 4'd1;
      end else if ((r_hr_t == 4'd1) && (r_hr_u == 4'd1)) begin
        r_hr_u <= 4'd2; r_am <= ~r_am;
      end else if (r_hr_u == 4'd9) begin
        r_hr_t <= 4'd1; r_hr_u <= 4'd0;
      end else begin
        r_hr_u <= r_hr_u + 4'd1;
      end
    end else if (w_inc_apply && (r_state == SET_MIN)) begin
      if (r_mn_u >= 4'd9) begin
        r_mn_u <= 4'd0;
        r_mn_t <= (r_mn_t >= 4'd5) ? 4'd0 : r_mn_t + 4'd1;
      end else begin
        r_mn_u <= r_mn_u + 4'd1;
      end
    end
  end

  always_comb begin
    w_run_en_next    = (w_state_next == RUN);
    w_load_next      = (w_state_next == COMMIT);
    w_sel_hour_next  = (w_state_next == SET_HOUR);
    w_sel_min_next   = (w_state_next == SET_MIN);
    w_blink_next     = 1'b0;
    w_blink_cnt_next = '0;
    if (w_next_in_set && w_enter_set) begin
      w_blink_next = 1'b1;
    end else if (w_next_in_set) begin
      if (r_blink_cnt == BLINK_W'(BLINK_CYC - 1)) begin
        w_blink_next = ~r_blink;
      end else begin
        w_blink_next     = r_blink;
        w_blink_cnt_next = r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run_en <= 1'b1; r_load <= 1'b0; r_sel_hour <= 1'b0; r_sel_min <= 1'b0;
      r_blink  <= 1'b0; r_blink_cnt <= '0;
    end else begin
      r_run_en <= w_run_en_next; r_load <= w_load_next;
      r_sel_hour <= w_sel_hour_next; r_sel_min <= w_sel_min_next;
      r_blink  <= w_blink_next; r_blink_cnt <= w_blink_cnt_next;
    end
  end

  assign set_hour_tens  = r_hr_t;
  assign set_hour_units = r_hr_u;
  assign set_min_tens   = r_mn_t;
  assign set_min_units  = r_mn_u;
  assign set_is_am      = r_am;
  assign load           = r_load;
  assign run_en         = r_run_en;
  assign sel_hour       = r_sel_hour;
  assign sel_min        = r_sel_min;
  assign blink          = r_blink;

endmodule
